cmos_pixel_capture: RTL and testbench

// - Camera-side input stage between the OV5640 DVP pins (cam_pclk/vsync/href/data) and the DDR3 write FIFO.
// - Skips WAIT_FRAME frames after reset so sensor configuration can settle, then aligns output to a whole-frame start.
// - Packs byte pairs into RGB565 pixels and forwards frame/line timing to the write-side frame buffer.

---
 rtl/cmos_pkg.sv | 20 ++
 rtl/cmos_pixel_capture_if.sv | 21 ++
 rtl/cmos_edge_det.sv | 26 ++
 rtl/cmos_pixel_capture.sv | 176 +++++++++++++++++
 tb/tb_cmos_pixel_capture.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmos_pkg.sv
// Shared definitions for the OV5640 DVP capture stage: FSM state encoding,
// RGB565 field widths and the default counter width.
package cmos_pkg;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam int R_W       = 5;
    localparam int G_W       = 6;
    localparam int B_W       = 5;
    localparam int PIX_W     = R_W + G_W + B_W;
    localparam int CNT_W_DEF = 12;

    // Sensor sends the high byte first, so it lands in the upper half of the pixel.
    function automatic logic [PIX_W-1:0] pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/cmos_pixel_capture_if.sv
// Write-side frame bus carrying packed pixels and frame/line timing toward the DDR3 write FIFO.
interface cmos_pixel_capture_if;
    import cmos_pkg::*;

    logic             cmos_frame_vsync;
    logic             cmos_frame_href;
    logic             cmos_frame_valid;
    logic [PIX_W-1:0] cmos_frame_data;
    logic             frame_done;
    logic             line_err;

    modport master (
        output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid,
        output cmos_frame_data, frame_done, line_err
    );

    modport slave (
        input cmos_frame_vsync, cmos_frame_href, cmos_frame_valid,
        input cmos_frame_data, frame_done, line_err
    );
endinterface

// File: rtl/cmos_edge_det.sv
// One-bit delay stage producing rise/fall pulses from the current and previous sample.
module cmos_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q_r;

    // Previous-cycle sample; resets to the line's idle level so no edge fires on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= d;
        end
    end

    assign rise = d & ~q_r;
    assign fall = ~d & q_r;

endmodule

// File: rtl/cmos_pixel_capture.sv
// DVP capture: skips WAIT_FRAME frames, aligns to a frame start, packs byte pairs to RGB565.
// Optional macro CMOS_CAPTURE_STATS_EN adds frame_width/frame_height measurement outputs.
module cmos_pixel_capture
    import cmos_pkg::*;
#(
    parameter logic [3:0] WAIT_FRAME = 4'd10,
    parameter logic       VSYNC_POL  = 1'b1,
    parameter int         CNT_W      = CNT_W_DEF
) (
    input  logic                 cam_pclk,
    input  logic                 rst_n,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic [7:0]           cam_data,
    cmos_pixel_capture_if.master frame_bus
`ifdef CMOS_CAPTURE_STATS_EN
    ,
    output logic [CNT_W-1:0]     frame_width,
    output logic [CNT_W-1:0]     frame_height
`endif
);

    logic       vsync_d1_r;
    logic       href_d1_r;
    logic [7:0] data_d1_r;
    logic       vsync_rise_s, vsync_fall_s;
    logic       href_rise_s, href_fall_s;
    logic       fs_s, fe_s;
    logic       phase_s, emit_s, run_s;
    logic       phase_r;
    logic [7:0] hi_r;
    logic [1:0] state_r;
    logic [3:0] wait_cnt_r;

    // Input capture stage (d1) on the sensor pins.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1_r <= ~VSYNC_POL;
            href_d1_r  <= 1'b0;
            data_d1_r  <= 8'd0;
        end else begin
            vsync_d1_r <= cam_vsync;
            href_d1_r  <= cam_href;
            data_d1_r  <= cam_data;
        end
    end

    cmos_edge_det #(.RST_VAL(~VSYNC_POL)) u_vsync_det (
        .clk(cam_pclk), .rst_n(rst_n), .d(vsync_d1_r), .rise(vsync_rise_s), .fall(vsync_fall_s)
    );

    cmos_edge_det #(.RST_VAL(1'b0)) u_href_det (
        .clk(cam_pclk), .rst_n(rst_n), .d(href_d1_r), .rise(href_rise_s), .fall(href_fall_s)
    );

    assign run_s = (state_r == S_RUN);

    // Frame boundaries and the byte phase seen by the current d1 byte (fs wins over a same-cycle byte).
    always_comb begin
        if (VSYNC_POL) begin
            fs_s = vsync_fall_s;
            fe_s = vsync_rise_s;
        end else begin
            fs_s = vsync_rise_s;
            fe_s = vsync_fall_s;
        end
        if (fs_s || href_rise_s) begin
            phase_s = 1'b0;
        end else begin
            phase_s = phase_r;
        end
        emit_s = href_d1_r & phase_s;
    end

    // Startup FSM: count frame starts, then wait for a clean frame start before running.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_WAIT;
            wait_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                S_WAIT: begin
                    if (wait_cnt_r == WAIT_FRAME) begin
                        state_r <= S_SYNC;
                    end else if (fs_s) begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                S_SYNC: begin
                    if (fs_s) begin
                        state_r <= S_RUN;
                    end
                end
                S_RUN:   state_r <= S_RUN;
                default: state_r <= S_WAIT;
            endcase
        end
    end

    // Byte packer: phase-0 byte held as the high half; phase is zero whenever href is low.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 1'b0;
            hi_r    <= 8'd0;
        end else if (href_d1_r) begin
            phase_r <= ~phase_s;
            if (!phase_s) begin
                hi_r <= data_d1_r;
            end
        end else begin
            phase_r <= 1'b0;
        end
    end

    // Registered frame bus; everything is held at its reset value until running.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_bus.cmos_frame_vsync <= ~VSYNC_POL;
            frame_bus.cmos_frame_href  <= 1'b0;
            frame_bus.cmos_frame_valid <= 1'b0;
            frame_bus.cmos_frame_data  <= {PIX_W{1'b0}};
            frame_bus.frame_done       <= 1'b0;
            frame_bus.line_err         <= 1'b0;
        end else if (run_s) begin
            frame_bus.cmos_frame_vsync <= vsync_d1_r;
            frame_bus.cmos_frame_href  <= href_d1_r;
            frame_bus.cmos_frame_valid <= emit_s;
            if (emit_s) begin
                frame_bus.cmos_frame_data <= pack_rgb565(hi_r, data_d1_r);
            end
            frame_bus.frame_done <= fe_s;
            frame_bus.line_err   <= href_fall_s & phase_r;
        end else begin
            frame_bus.cmos_frame_vsync <= ~VSYNC_POL;
            frame_bus.cmos_frame_href  <= 1'b0;
            frame_bus.cmos_frame_valid <= 1'b0;
            frame_bus.cmos_frame_data  <= {PIX_W{1'b0}};
            frame_bus.frame_done       <= 1'b0;
            frame_bus.line_err         <= 1'b0;
        end
    end

`ifdef CMOS_CAPTURE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] pix_cnt_r;
    logic [CNT_W-1:0] line_cnt_r;

    // Saturating pixel/line counters, latched into the outputs at each forwarded frame end.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_r    <= {CNT_W{1'b0}};
            line_cnt_r   <= {CNT_W{1'b0}};
            frame_width  <= {CNT_W{1'b0}};
            frame_height <= {CNT_W{1'b0}};
        end else begin
            if (href_rise_s) begin
                pix_cnt_r <= {CNT_W{1'b0}};
            end else if (emit_s && (pix_cnt_r != CNT_MAX)) begin
                pix_cnt_r <= pix_cnt_r + CNT_ONE;
            end
            if (fs_s) begin
                line_cnt_r <= href_rise_s ? CNT_ONE : {CNT_W{1'b0}};
            end else if (href_rise_s && (line_cnt_r != CNT_MAX)) begin
                line_cnt_r <= line_cnt_r + CNT_ONE;
            end
            if (run_s && fe_s) begin
                frame_width  <= pix_cnt_r;
                frame_height <= line_cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Randomized bench for cmos_pixel_capture: a WAIT_FRAME=2 instance and a WAIT_FRAME=0 instance
// share the sensor pins; pixels expected are built from the driven byte stream.
module tb_cmos_pixel_capture;
    import cmos_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst0_n;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    always #5 clk = ~clk;

    cmos_pixel_capture_if bus ();
    cmos_pixel_capture_if bus0 ();

`ifdef CMOS_CAPTURE_STATS_EN
    logic [11:0] fw, fh, fw0, fh0;
`endif

    cmos_pixel_capture #(.WAIT_FRAME(4'd2), .VSYNC_POL(1'b1), .CNT_W(12)) dut (
        .cam_pclk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .frame_bus(bus)
`ifdef CMOS_CAPTURE_STATS_EN
        , .frame_width(fw), .frame_height(fh)
`endif
    );

    cmos_pixel_capture #(.WAIT_FRAME(4'd0), .VSYNC_POL(1'b1), .CNT_W(12)) dut0 (
        .cam_pclk(clk), .rst_n(rst0_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .frame_bus(bus0)
`ifdef CMOS_CAPTURE_STATS_EN
        , .frame_width(fw0), .frame_height(fh0)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Monitor: records strobed pixels and counts pulses; tasks only read these.
    logic [15:0] obs_q[$];
    logic [15:0] obs0_q[$];
    int done_n = 0, err_n = 0, vs_n = 0, done0_n = 0;

    always @(negedge clk) begin
        if (bus.cmos_frame_valid === 1'b1) obs_q.push_back(bus.cmos_frame_data);
        if (bus.frame_done === 1'b1) done_n++;
        if (bus.line_err === 1'b1) err_n++;
        if (bus.cmos_frame_vsync === 1'b1) vs_n++;
        if (bus0.cmos_frame_valid === 1'b1) obs0_q.push_back(bus0.cmos_frame_data);
        if (bus0.frame_done === 1'b1) done0_n++;
    end

    // Reference: each pair of bytes within a line is one pixel {first, second}; odd tail dropped.
    logic [15:0] exp_q[$];
    logic [15:0] exp0_q[$];

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        cam_vsync = v;
        cam_href  = h;
        cam_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd0);
        idle(4);
    endtask

    task automatic drive_line(input int nbytes, input bit rec, input bit rec0);
        logic [7:0] prev;
        logic [7:0] b;
        prev = 8'd0;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom_range(0, 255));
            step(1'b0, 1'b1, b);
            if (i % 2 == 1) begin
                if (rec)  exp_q.push_back({prev, b});
                if (rec0) exp0_q.push_back({prev, b});
            end
            prev = b;
        end
        idle(4);
    endtask

    task automatic drive_frame(input bit rec, input bit rec0);
        for (int l = 0; l < 4; l++) drive_line(64, rec, rec0);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst0_n = 1'b0;
        idle(3);
        checks++; if (bus.cmos_frame_vsync !== 1'b0) begin errors++; $display("FAIL rst_vsync: got %0b want 0", bus.cmos_frame_vsync); end
        checks++; if (bus.cmos_frame_href !== 1'b0) begin errors++; $display("FAIL rst_href: got %0b want 0", bus.cmos_frame_href); end
        checks++; if (bus.cmos_frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.cmos_frame_valid); end
        checks++; if (bus.cmos_frame_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", bus.cmos_frame_data); end
        checks++; if (bus.frame_done !== 1'b0 || bus.line_err !== 1'b0) begin errors++; $display("FAIL rst_pulses: got done=%0b err=%0b want 0/0", bus.frame_done, bus.line_err); end
`ifdef CMOS_CAPTURE_STATS_EN
        checks++; if (fw !== 12'd0 || fh !== 12'd0) begin errors++; $display("FAIL rst_stats: got %0d/%0d want 0/0", fw, fh); end
`endif
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_wait_frames();
        int s, d0, v0, n;
        logic [15:0] got;
        s = obs_q.size(); d0 = done_n; v0 = vs_n;
        vsync_pulse(); drive_frame(1'b0, 1'b0);
        vsync_pulse(); drive_frame(1'b0, 1'b0);
        checks++; if (obs_q.size() - s !== 0) begin errors++; $display("FAIL skip_valid: got %0d strobes want 0", obs_q.size() - s); end
        checks++; if (vs_n - v0 !== 0) begin errors++; $display("FAIL skip_vsync: got %0d high cycles want 0", vs_n - v0); end
        vsync_pulse();
        checks++; if (done_n - d0 !== 0) begin errors++; $display("FAIL skip_done: got %0d want 0", done_n - d0); end
        exp_q.delete(); s = obs_q.size(); d0 = done_n;
        drive_frame(1'b1, 1'b0);
        vsync_pulse();
        n = obs_q.size() - s;
        checks++; if (n !== 128) begin errors++; $display("FAIL f3_count: got %0d want 128", n); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (s + i < obs_q.size()) ? obs_q[s + i] : 16'hxxxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL f3_pix[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL f3_done: got %0d want 1", done_n - d0); end
`ifdef CMOS_CAPTURE_STATS_EN
        checks++; if (fw !== 12'd32) begin errors++; $display("FAIL f3_width: got %0d want 32", fw); end
        checks++; if (fh !== 12'd4) begin errors++; $display("FAIL f3_height: got %0d want 4", fh); end
`endif
    endtask

    task automatic test_latency();
        int e0;
        e0 = err_n;
        step(1'b0, 1'b1, 8'hF8);
        step(1'b0, 1'b1, 8'h1F);
        checks++; if (bus.cmos_frame_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %0b want 0", bus.cmos_frame_valid); end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (bus.cmos_frame_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0b want 1", bus.cmos_frame_valid); end
        checks++; if (bus.cmos_frame_data !== 16'hF81F) begin errors++; $display("FAIL lat_data: got %h want F81F", bus.cmos_frame_data); end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (bus.cmos_frame_valid !== 1'b0) begin errors++; $display("FAIL lat_pulse: got %0b want 0", bus.cmos_frame_valid); end
        idle(3);
        checks++; if (err_n - e0 !== 0) begin errors++; $display("FAIL lat_lineerr: got %0d want 0", err_n - e0); end
    endtask

    task automatic test_odd_line();
        int s, e0, n;
        logic [15:0] got;
        exp_q.delete(); s = obs_q.size(); e0 = err_n;
        drive_line(63, 1'b1, 1'b0);
        checks++; if (obs_q.size() - s !== 31) begin errors++; $display("FAIL odd_count: got %0d want 31", obs_q.size() - s); end
        checks++; if (err_n - e0 !== 1) begin errors++; $display("FAIL odd_lineerr: got %0d want 1", err_n - e0); end
        drive_line(64, 1'b1, 1'b0);
        n = obs_q.size() - s;
        checks++; if (n !== 63) begin errors++; $display("FAIL odd_total: got %0d want 63", n); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (s + i < obs_q.size()) ? obs_q[s + i] : 16'hxxxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL odd_pix[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        vsync_pulse();
    endtask

    task automatic test_reset_run();
        int s, d0, n;
        logic [15:0] got;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        checks++; if (bus.cmos_frame_href !== 1'b1) begin errors++; $display("FAIL run_href: got %0b want 1", bus.cmos_frame_href); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.cmos_frame_href !== 1'b0) begin errors++; $display("FAIL arst_href: got %0b want 0", bus.cmos_frame_href); end
        checks++; if (bus.cmos_frame_vsync !== 1'b0 || bus.cmos_frame_valid !== 1'b0) begin errors++; $display("FAIL arst_vs_valid: got %0b/%0b want 0/0", bus.cmos_frame_vsync, bus.cmos_frame_valid); end
        checks++; if (bus.cmos_frame_data !== 16'h0000) begin errors++; $display("FAIL arst_data: got %h want 0000", bus.cmos_frame_data); end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        idle(4);
        s = obs_q.size(); d0 = done_n;
        vsync_pulse(); drive_frame(1'b0, 1'b0);
        vsync_pulse(); drive_frame(1'b0, 1'b0);
        vsync_pulse();
        checks++; if (obs_q.size() - s !== 0) begin errors++; $display("FAIL rerun_skip: got %0d strobes want 0", obs_q.size() - s); end
        checks++; if (done_n - d0 !== 0) begin errors++; $display("FAIL rerun_skipdone: got %0d want 0", done_n - d0); end
        exp_q.delete(); s = obs_q.size(); d0 = done_n;
        drive_frame(1'b1, 1'b0);
        vsync_pulse();
        n = obs_q.size() - s;
        checks++; if (n !== 128) begin errors++; $display("FAIL rerun_count: got %0d want 128", n); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (s + i < obs_q.size()) ? obs_q[s + i] : 16'hxxxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rerun_pix[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL rerun_done: got %0d want 1", done_n - d0); end
    endtask

    task automatic test_wait0();
        int s, d0, n;
        logic [15:0] got;
        s = obs0_q.size();
        drive_line(64, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            if (i == 29) rst0_n = 1'b1;
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
        end
        idle(4);
        drive_line(64, 1'b0, 1'b0);
        checks++; if (obs0_q.size() - s !== 0) begin errors++; $display("FAIL w0_partial: got %0d strobes want 0", obs0_q.size() - s); end
        vsync_pulse();
        exp0_q.delete(); s = obs0_q.size(); d0 = done0_n;
        drive_frame(1'b0, 1'b1);
        vsync_pulse();
        n = obs0_q.size() - s;
        checks++; if (n !== 128) begin errors++; $display("FAIL w0_count: got %0d want 128", n); end
        for (int i = 0; i < exp0_q.size(); i++) begin
            got = (s + i < obs0_q.size()) ? obs0_q[s + i] : 16'hxxxx;
            checks++; if (got !== exp0_q[i]) begin errors++; $display("FAIL w0_pix[%0d]: got %h want %h", i, got, exp0_q[i]); end
        end
        checks++; if (done0_n - d0 !== 1) begin errors++; $display("FAIL w0_done: got %0d want 1", done0_n - d0); end
    endtask

    initial begin
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'd0;
        rst_n     = 1'b0;
        rst0_n    = 1'b0;
        test_reset();
        test_wait_frames();
        test_latency();
        test_odd_line();
        test_reset_run();
        test_wait0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
